// File: rtl/pixel_compositor_if.sv
// Pixel-pair input and SDRAM write-FIFO output bundle for pixel_compositor.
// The slave modport is the compositor's view. The master modport is the upstream/downstream view.
interface pixel_compositor_if;
    logic        val;
    logic [9:0]  sync_x;
    logic [9:0]  sync_y;
    logic [4:0]  dvi_r;
    logic [5:0]  dvi_g;
    logic [4:0]  dvi_b;
    logic [4:0]  ccd_r;
    logic [5:0]  ccd_g;
    logic [4:0]  ccd_b;
    logic [1:0]  mode;
    logic [4:0]  alpha;
    logic        clr_ovf;
    logic        wrfull;
    logic        wrreq;
    logic [18:0] wr_addr;
    logic [15:0] wr_data;
    logic        frame_start;
    logic        overflow;

    modport slave (
        input  val, sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b,
               mode, alpha, clr_ovf, wrfull,
        output wrreq, wr_addr, wr_data, frame_start, overflow
    );

    modport master (
        output val, sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b,
               mode, alpha, clr_ovf, wrfull,
        input  wrreq, wr_addr, wr_data, frame_start, overflow
    );
endinterface

// File: rtl/pixel_compositor.sv
// Composites DVI and CCD RGB565 pixels, forms the frame-buffer address and queues the
// result in a small skid FIFO toward the SDRAM write FIFO.
module pc_chan #(
    parameter int W = 5
) (
    input  logic         clk_25,
    input  logic         rst_n,
    input  logic         ld,
    input  logic         en2,
    input  logic [4:0]   a,
    input  logic [W-1:0] dvi,
    input  logic [W-1:0] ccd,
    input  logic [1:0]   sel,
    output logic [W-1:0] out
);
    localparam int PW = W + 4;

    logic [PW-1:0] s1_p, sum;
    logic [W-1:0]  s1_dvi, s1_ccd;
    logic [4:0]    inv_a;

    assign inv_a = 5'd16 - a;
    // The maximum is 16*(2^W-1)+8. This still fits in PW bits, so the rounding add cannot wrap.
    assign sum   = s1_p + PW'(8);

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            s1_p   <= '0;
            s1_dvi <= '0;
            s1_ccd <= '0;
            out    <= '0;
        end else begin
            if (ld) begin
                s1_p   <= PW'(ccd) * PW'(a) + PW'(dvi) * PW'(inv_a);
                s1_dvi <= dvi;
                s1_ccd <= ccd;
            end
            if (en2) begin
                case (sel)
                    2'd0:    out <= s1_dvi;
                    2'd1:    out <= s1_ccd;
                    default: out <= sum[PW-1:4];
                endcase
            end
        end
    end
endmodule

module pixel_compositor #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int SPLIT_X    = 320,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_25,
    input  logic              rst_n,
    pixel_compositor_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [18:0] addr;
        logic [15:0] data;
    } wr_ent_t;

    logic        first;
    logic [4:0]  a_clamp, sh_alpha, eff_a;
    logic [1:0]  sh_mode, eff_mode, s1_mode, sel2;
    logic [2:1]  vld_pipe;
    logic [9:0]  s1_x, s1_y;
    logic        s1_inr;
    logic [18:0] s2_addr;
    logic [4:0]  s2_r, s2_b;
    logic [5:0]  s2_g;

    wr_ent_t [FIFO_DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, push, pop, push_ok, drop;
    wr_ent_t          head;

    // Pixel (0,0) reloads the frame config and uses it at once. Every other pixel uses the shadow copy.
    assign first    = bus.val && (bus.sync_x == 10'd0) && (bus.sync_y == 10'd0);
    assign a_clamp  = (bus.alpha > 5'd16) ? 5'd16 : bus.alpha;
    assign eff_mode = first ? bus.mode : sh_mode;
    assign eff_a    = first ? a_clamp  : sh_alpha;
    assign sel2     = (s1_mode == 2'd3) ? ((s1_x < 10'(SPLIT_X)) ? 2'd0 : 2'd1) : s1_mode;

    pc_chan #(.W(5)) u_chan_r (.clk_25(clk_25), .rst_n(rst_n), .ld(bus.val), .en2(vld_pipe[1]),
        .a(eff_a), .dvi(bus.dvi_r), .ccd(bus.ccd_r), .sel(sel2), .out(s2_r));
    pc_chan #(.W(6)) u_chan_g (.clk_25(clk_25), .rst_n(rst_n), .ld(bus.val), .en2(vld_pipe[1]),
        .a(eff_a), .dvi(bus.dvi_g), .ccd(bus.ccd_g), .sel(sel2), .out(s2_g));
    pc_chan #(.W(5)) u_chan_b (.clk_25(clk_25), .rst_n(rst_n), .ld(bus.val), .en2(vld_pipe[1]),
        .a(eff_a), .dvi(bus.dvi_b), .ccd(bus.ccd_b), .sel(sel2), .out(s2_b));

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe        <= '0;
            sh_mode         <= 2'd0;
            sh_alpha        <= 5'd8;
            bus.frame_start <= 1'b0;
            s1_x            <= '0;
            s1_y            <= '0;
            s1_inr          <= 1'b0;
            s1_mode         <= '0;
            s2_addr         <= '0;
        end else begin
            vld_pipe        <= {vld_pipe[1] && s1_inr, bus.val};
            bus.frame_start <= first;
            if (first) begin
                sh_mode  <= bus.mode;
                sh_alpha <= a_clamp;
            end
            if (bus.val) begin
                s1_x    <= bus.sync_x;
                s1_y    <= bus.sync_y;
                s1_inr  <= (bus.sync_x < 10'(H_ACTIVE)) && (bus.sync_y < 10'(V_ACTIVE));
                s1_mode <= eff_mode;
            end
            if (vld_pipe[1])
                s2_addr <= 19'(s1_y) * 19'(H_ACTIVE) + 19'(s1_x);
        end
    end

    // Skid FIFO. When full, a push is accepted only if a pop frees a slot on the same edge.
    assign head        = mem[rd_ptr];
    assign full        = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign bus.wrreq   = (count != '0) && !bus.wrfull;
    assign bus.wr_addr = head.addr;
    assign bus.wr_data = head.data;
    assign push        = vld_pipe[2];
    assign pop         = bus.wrreq;
    assign push_ok     = push && (!full || pop);
    assign drop        = push && full && !pop;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            mem          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= '{addr: s2_addr, data: {s2_r, s2_g, s2_b}};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)
                bus.overflow <= 1'b1;
            else if (bus.clr_ovf)
                bus.overflow <= 1'b0;
        end
    end
endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
- Sits directly downstream of the DVI/CCD sync stage.
- Consumes each synchronised pixel pair (val, sync_x, sync_y, DVI RGB565, CCD RGB565) and composites the two sources per a selectable mode.
- Computes the linear frame-buffer address.
- Pushes {address, RGB565} through a 4-entry skid FIFO toward the SDRAM write-FIFO interface, flagging dropped pixels.

Parameters:
- H_ACTIVE, 640, active pixels per line; also the address stride.
- V_ACTIVE, 480, active lines per frame.
- SPLIT_X, 320, first x column showing CCD in split mode.
- FIFO_DEPTH, 4, skid FIFO entries; must be a power of 2.

Ports:
- clk_25 input 1: pixel clock.
- rst_n input 1: asynchronous, active-low reset.
- val input 1: pixel pair valid, single-cycle.
- sync_x input 10: pixel x.
- sync_y input 10: pixel y.
- dvi_r input 5; dvi_g input 6; dvi_b input 5: DVI pixel.
- ccd_r input 5; ccd_g input 6; ccd_b input 5: CCD pixel.
- mode input 2: 0=DVI only, 1=CCD only, 2=alpha blend, 3=split screen.
- alpha input 5: CCD weight in sixteenths; values >16 clamp to 16.
- clr_ovf input 1: clears the overflow flag.
- wrfull input 1: downstream write FIFO full.
- wrreq output 1: write strobe.
- wr_addr output 19: sync_y*H_ACTIVE + sync_x.
- wr_data output 16: composited {r5,g6,b5}.
- frame_start output 1: one-cycle pulse.
- overflow output 1: sticky drop flag.

Behaviour:
- Reset values:
  - All pipeline valids, FIFO pointers and count = 0.
  - overflow=0, frame_start=0.
  - Shadow mode=0, shadow alpha=8.
  - Because of the FIFO state above, wrreq=0, wr_addr=0 and wr_data=0.
  - Reset mid-operation discards all in-flight and queued pixels.
- Shadow config:
  - mode and alpha (after clamp) load into shadow regs only on the edge where val=1 with sync_x=0 and sync_y=0.
  - Pixel (0,0) itself uses the newly loaded values.
  - All other pixels use the shadow values, so there is no mid-frame tearing.
  - Pixel (0,0) with val=1 also registers frame_start=1 for exactly one cycle after that edge.
- S1, loaded on the edge where val=1:
  - Register x, y and the range-check bit: in_range = (x<H_ACTIVE && y<V_ACTIVE).
  - Register per-channel products P = ccd*a + dvi*(16-a), where a = effective alpha.
  - Register the effective mode.
  - Product widths: 9 bits for r/b, 10 bits for g.
- S2, next edge:
  - Per channel: out = (P+8)>>4 in blend mode; the result cannot exceed 31 (r/b) or 63 (g).
  - Mode 0 selects dvi; mode 1 selects ccd.
  - Mode 3 selects dvi for x<SPLIT_X, otherwise ccd.
  - Address = y*H_ACTIVE + x, 19 bits unsigned.
  - s2_valid = s1_valid && in_range. Out-of-range pixels are silently discarded and do not set overflow.
- FIFO push:
  - Occurs on the edge after S2 when s2_valid=1.
  - Latency: val edge to wrreq high is 3 edges, when the FIFO is empty and wrfull=0.
- FIFO output:
  - wrreq = !empty && !wrfull, combinational.
  - wr_addr and wr_data are the FIFO head, held stable while wrreq=0.
  - Pop occurs on any edge with wrreq=1.
- Boundaries:
  - Push and pop on the same edge: allowed even when full; count is unchanged.
  - Push while full with no pop: pixel dropped, FIFO contents unchanged, overflow<=1.
  - Push while empty: the entry becomes visible on the next cycle; there is no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
  - overflow clears only when clr_ovf=1 and there is no drop on the same edge; a drop wins.
- Back-to-back val=1 on every cycle is supported: throughput is 1 pixel per clock when wrfull=0.

Test Plan:
- Reset, then mode=2, alpha=8, pixel (0,0) with dvi=(31,63,31), ccd=0:
  - wrreq rises 3 edges later with wr_addr=0 and wr_data={5'd16,6'd32,5'd16}.
  - frame_start pulses 1 cycle after the val edge.
- Pixel (0,0) with mode=3, then pixels (319,5) and (320,5) with distinct dvi/ccd colours:
  - addr 3519 carries the dvi colour; addr 3520 carries the ccd colour.
  - Change mode to 1 mid-frame: no effect until the next (0,0) pixel.
- alpha=20 with mode=2: output equals the ccd pixel exactly (clamped to 16).
- alpha=0 with mode=2: output equals the dvi pixel.
- Hold wrfull=1 and send 6 consecutive pixels:
  - 4 are queued and overflow=1.
  - Release wrfull: exactly 4 writes in order, oldest first.
  - Pulse clr_ovf: overflow returns to 0.
- Pixel (640,0) and pixel (0,480): no wrreq and overflow stays 0.
- Assert rst_n=0 mid-stream with 3 pixels queued: wrreq=0 immediately and no stale pixel appears after release.
